// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Contents: ALU opcode constants, datapath widths, arbiter FSM state type,
//           and an opcode legality helper.
package alu_pkg;

    localparam int OP_W   = 5;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 4;

    localparam logic [OP_W-1:0] NOP  = 5'd0;
    localparam logic [OP_W-1:0] ANDS = 5'd1;
    localparam logic [OP_W-1:0] ORRS = 5'd2;
    localparam logic [OP_W-1:0] MVNS = 5'd3;
    localparam logic [OP_W-1:0] EORS = 5'd4;
    localparam logic [OP_W-1:0] ADCS = 5'd5;
    localparam logic [OP_W-1:0] ADDS = 5'd6;
    localparam logic [OP_W-1:0] SBCS = 5'd7;
    localparam logic [OP_W-1:0] SUB  = 5'd8;
    localparam logic [OP_W-1:0] MULS = 5'd9;
    localparam logic [OP_W-1:0] LSRS = 5'd10;
    localparam logic [OP_W-1:0] LSLS = 5'd11;
    localparam logic [OP_W-1:0] ASR  = 5'd12;
    localparam logic [OP_W-1:0] ROR  = 5'd13;
    localparam logic [OP_W-1:0] UXTB = 5'd14;
    localparam logic [OP_W-1:0] UXTH = 5'd15;
    localparam logic [OP_W-1:0] SXTB = 5'd16;
    localparam logic [OP_W-1:0] SXTH = 5'd17;
    localparam logic [OP_W-1:0] CMP  = 5'd18;

    localparam logic [OP_W-1:0] OP_MAX = CMP;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    // Opcodes 1..OP_MAX are executable; NOP and anything above OP_MAX is rejected.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op != NOP) && (op <= OP_MAX);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bus of the ALU arbiter.
// Signals: req_valid/req_ready per requester, packed req_op/req_a/req_b,
//          single response channel rsp_valid/rsp_ready with rsp_id,
//          rsp_result, rsp_flags, rsp_err.
// Modports: slave = arbiter side, master = requester/consumer side.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) ();
    import alu_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [OP_W*NUM_REQ-1:0]   req_op;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic [FLAG_W-1:0]         rsp_flags;
    logic                      rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports: req   - request vector
//        ptr   - highest-priority index (must be < NUM_REQ)
//        grant - one-hot grant, zero when no request
//        idx   - encoded winner index
//        any   - at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int                 j;
        logic [PTR_W-1:0]   j_idx;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        j_idx = '0;
        // Search upward from ptr with wrap; first hit wins.
        for (int off = 0; off < NUM_REQ; off++) begin
            j     = (int'(ptr) + off) % NUM_REQ;
            j_idx = PTR_W'(j);
            if (!any && req[j_idx]) begin
                any          = 1'b1;
                grant[j_idx] = 1'b1;
                idx          = j_idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, one
// transaction in flight at a time.
// Ports: clk, rst_n (async active-low)
//        bus             - requester/response interface (slave side)
//        alu_instruction - opcode to ALU, NOP outside EXEC
//        alu_num1/num2   - operands to ALU, zero outside EXEC
//        alu_result/flags- registered ALU outputs, valid ALU_LAT cycles
//                          after the inputs are applied
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [OP_W-1:0]   alu_instruction,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    arb_state_t          state;
    logic [PTR_W-1:0]    ptr;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    win_idx;
    logic                win_any;
    logic [PTR_W-1:0]    next_ptr;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Ready is offered only in IDLE; gating with rst_n keeps it low while
    // reset is held even if requests are pending.
    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;

    assign sel_op   = bus.req_op[OP_W*win_idx +: OP_W];
    assign sel_a    = bus.req_a[DATA_W*win_idx +: DATA_W];
    assign sel_b    = bus.req_b[DATA_W*win_idx +: DATA_W];
    assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

    // The ALU input registers double as the captured request: loaded on
    // accept of a legal op, held through EXEC, cleared on the way to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            cnt             <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_result  <= '0;
            bus.rsp_flags   <= '0;
            bus.rsp_err     <= 1'b0;
            alu_instruction <= NOP;
            alu_num1        <= '0;
            alu_num2        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        bus.rsp_id <= ID_W'(win_idx);
                        ptr        <= next_ptr;
                        if (op_legal(sel_op)) begin
                            alu_instruction <= sel_op;
                            alu_num1        <= sel_a;
                            alu_num2        <= sel_b;
                            cnt             <= '0;
                            state           <= EXEC;
                        end else begin
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_result <= '0;
                            bus.rsp_flags  <= '0;
                            bus.rsp_valid  <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ALU_LAT)) begin
                        bus.rsp_result  <= alu_result;
                        bus.rsp_flags   <= alu_flags;
                        bus.rsp_err     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        alu_instruction <= NOP;
                        alu_num1        <= '0;
                        alu_num2        <= '0;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [OP_W-1:0]   alu_instruction;
    logic [DATA_W-1:0] alu_num1;
    logic [DATA_W-1:0] alu_num2;
    logic [DATA_W-1:0] alu_result;
    logic [FLAG_W-1:0] alu_flags;

    int checks = 0;
    int errors = 0;

    alu_arbiter_if #(.NUM_REQ(2), .ID_W(1)) bus ();

    alu_arbiter #(
        .NUM_REQ (2),
        .ID_W    (1),
        .ALU_LAT (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .alu_instruction (alu_instruction),
        .alu_num1        (alu_num1),
        .alu_num2        (alu_num2),
        .alu_result      (alu_result),
        .alu_flags       (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: flags are {N,Z,C,V}; CMP returns result 0 with subtract flags.
    function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            ANDS: r = a & b;
            ADDS: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            SUB, CMP: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = w[31:0]; c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            MULS: r = a * b;
            default: r = '0;
        endcase
        alu_model = {(op == CMP) ? 32'd0 : r, r[31], (r == 32'd0) && (op != NOP), c, v};
    endfunction

    always @(posedge clk) begin
        {alu_result, alu_flags} <= alu_model(alu_instruction, alu_num1, alu_num2);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_op[5*i +: 5]  = op;
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 8) begin
            check({tag, "_onehot"}, 64'($onehot0(bus.req_ready)), 64'd1);
            tick();
            n++;
        end
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_alu_instr", 64'(alu_instruction), 64'd0);
        check("rst_alu_num1", 64'(alu_num1), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single request: ANDS 15 & 10
        set_req(0, ANDS, 32'd15, 32'd10);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'd1);
        check("single_instr_t0", 64'(alu_instruction), 64'd0);
        tick();
        bus.req_valid = 2'b00;
        check("single_instr_t1", 64'(alu_instruction), 64'd1);
        check("single_num1_t1", 64'(alu_num1), 64'd15);
        check("single_valid_t1", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("single_instr_t2", 64'(alu_instruction), 64'd1);
        check("single_valid_t2", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("single_valid_t3", 64'(bus.rsp_valid), 64'd1);
        check("single_id", 64'(bus.rsp_id), 64'd0);
        check("single_result", 64'(bus.rsp_result), 64'd10);
        check("single_flags", 64'(bus.rsp_flags), 64'd0);
        check("single_err", 64'(bus.rsp_err), 64'd0);
        check("single_instr_t3", 64'(alu_instruction), 64'd0);
        tick();
        check("single_valid_t4", 64'(bus.rsp_valid), 64'd0);

        // Illegal opcode from requester 1 (pointer is 1 now)
        set_req(1, 5'd25, 32'd7, 32'd9);
        bus.req_valid = 2'b10;
        #1;
        check("ill_ready", 64'(bus.req_ready), 64'd2);
        tick();
        bus.req_valid = 2'b00;
        check("ill_valid_t1", 64'(bus.rsp_valid), 64'd1);
        check("ill_err", 64'(bus.rsp_err), 64'd1);
        check("ill_result", 64'(bus.rsp_result), 64'd0);
        check("ill_flags", 64'(bus.rsp_flags), 64'd0);
        check("ill_id", 64'(bus.rsp_id), 64'd1);
        check("ill_instr", 64'(alu_instruction), 64'd0);
        tick();
        check("ill_valid_t2", 64'(bus.rsp_valid), 64'd0);
        check("ill_instr_t2", 64'(alu_instruction), 64'd0);

        // Contention: both held valid, grants must alternate 0,1,0,1
        set_req(0, ADDS, 32'd51526, 32'd4294967200);
        set_req(1, SUB, 32'd16, 32'd4);
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("ctn_grant", 64'(bus.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            wait_rsp("ctn");
            check("ctn_id", 64'(bus.rsp_id), 64'(k % 2));
            check("ctn_result", 64'(bus.rsp_result), (k % 2 == 0) ? 64'd51430 : 64'd12);
            if (k % 2 == 0) check("ctn_flags_adds", 64'(bus.rsp_flags), 64'h2);
            tick();
        end
        bus.req_valid = 2'b00;
        tick();

        // Backpressure: MULS 5*4 held for 5 cycles, req1 pending meanwhile
        set_req(0, MULS, 32'd5, 32'd4);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_ready", 64'(bus.req_ready), 64'd1);
        tick();
        set_req(1, ANDS, 32'd15, 32'd10);
        bus.req_valid = 2'b10;
        wait_rsp("bp");
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_hold_result", 64'(bus.rsp_result), 64'd20);
            check("bp_hold_id", 64'(bus.rsp_id), 64'd0);
            check("bp_hold_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
        check("bp_pending_ready", 64'(bus.req_ready), 64'd2);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("bp2");
        check("bp2_result", 64'(bus.rsp_result), 64'd10);
        check("bp2_id", 64'(bus.rsp_id), 64'd1);
        tick();

        // Flags passthrough: CMP 22 vs 32 -> N set, C clear
        set_req(0, CMP, 32'd22, 32'd32);
        bus.req_valid = 2'b01;
        #1;
        check("cmp_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("cmp");
        check("cmp_flags", 64'(bus.rsp_flags), 64'h8);
        check("cmp_result", 64'(bus.rsp_result), 64'd0);
        check("cmp_err", 64'(bus.rsp_err), 64'd0);
        tick();

        // Reset during EXEC cycle 1; pointer is 1 before the reset
        set_req(0, ADDS, 32'd1, 32'd2);
        bus.req_valid = 2'b01;
        #1;
        check("rx_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 2'b00;
        check("rx_exec_instr", 64'(alu_instruction), 64'(ADDS));
        #2;
        rst_n = 1'b0;
        #1;
        check("rx_instr", 64'(alu_instruction), 64'd0);
        check("rx_num1", 64'(alu_num1), 64'd0);
        check("rx_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        tick();
        check("rx_no_rsp", 64'(bus.rsp_valid), 64'd0);
        rst_n = 1'b1;
        set_req(0, SUB, 32'd16, 32'd4);
        set_req(1, ADDS, 32'd1, 32'd2);
        bus.req_valid = 2'b11;
        #1;
        check("rx_ptr_zero_grant", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp("rx");
        check("rx_result", 64'(bus.rsp_result), 64'd12);
        check("rx_id", 64'(bus.rsp_id), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
